// File: rtl/rsa_dma_ctrl.sv
// Command/DMA sequencer for the RSA accelerator: key loads, message fetch, core handshake, write-back.
// Optional compute cycle counter enabled by defining CYCLE_COUNT_EN.
module rsa_dma_ctrl #(
    parameter int unsigned DW             = 1024,
    parameter int unsigned NUM_KEYS       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [31:0]            cmd,
    input  logic [31:0]            load_sel,
    input  logic [31:0]            rx_addr,
    input  logic [31:0]            tx_addr,
    output logic [31:0]            status,
    output logic [31:0]            cycles,
    input  logic [DW-1:0]          dma_rx_data,
    output logic [DW-1:0]          dma_tx_data,
    output logic [31:0]            dma_rx_address,
    output logic [31:0]            dma_tx_address,
    output logic                   dma_rx_start,
    output logic                   dma_tx_start,
    input  logic                   dma_done,
    input  logic                   dma_idle,
    input  logic                   dma_error,
    output logic                   core_start,
    output logic [DW-1:0]          core_operand,
    input  logic                   core_done,
    input  logic [DW-1:0]          core_result,
    output logic [NUM_KEYS*DW-1:0] key_bus
);

    typedef enum logic [3:0] {
        StIdle      = 4'd0,
        StRx        = 4'd1,
        StRxWait    = 4'd2,
        StSave      = 4'd3,
        StCoreStart = 4'd4,
        StCoreWait  = 4'd5,
        StTx        = 4'd6,
        StTxWait    = 4'd7,
        StDone      = 4'd8,
        StErr       = 4'd9
    } state_e;

    localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES) - 32'd1;

    state_e        state_q, state_d;
    logic          job_cmp_q, job_cmp_d;
    logic [31:0]   wait_cnt_q, wait_cnt_d;
    logic [DW-1:0] rx_buf_q, rx_buf_d;
    logic [DW-1:0] msg_q, msg_d;
    logic [DW-1:0] res_q, res_d;
    logic [DW-1:0] key_q [NUM_KEYS];
    logic [DW-1:0] key_d [NUM_KEYS];
    logic          err_q, err_d, tmo_q, tmo_d, bad_q, bad_d;
    logic          rx_start_q, rx_start_d, tx_start_q, tx_start_d, core_start_q, core_start_d;
    logic          timeout_hit, sel_ok;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt_q == TimeoutLast);
    assign sel_ok      = (load_sel >= 32'd1) && (load_sel <= 32'(NUM_KEYS));

    always_comb begin
        state_d      = state_q;
        job_cmp_d    = job_cmp_q;
        rx_buf_d     = rx_buf_q;
        msg_d        = msg_q;
        res_d        = res_q;
        key_d        = key_q;
        err_d        = err_q;
        tmo_d        = tmo_q;
        bad_d        = bad_q;
        rx_start_d   = 1'b0;
        tx_start_d   = 1'b0;
        core_start_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (cmd == 32'd1 || load_sel != 32'd0) begin
                    state_d   = StRx;
                    job_cmp_d = (cmd == 32'd1);
                    err_d     = 1'b0;
                    tmo_d     = 1'b0;
                    bad_d     = 1'b0;
                end
            end
            StRx: begin
                if (dma_error) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                end else if (dma_idle) begin
                    rx_start_d = 1'b1;
                    state_d    = StRxWait;
                end
            end
            StRxWait: begin
                if (dma_error) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                end else if (dma_done) begin
                    if (job_cmp_q) begin
                        msg_d   = dma_rx_data;
                        state_d = StCoreStart;
                    end else begin
                        rx_buf_d = dma_rx_data;
                        state_d  = StSave;
                    end
                end else if (timeout_hit) begin
                    state_d = StErr;
                    tmo_d   = 1'b1;
                end
            end
            StSave: begin
                for (int k = 0; k < NUM_KEYS; k++) begin
                    if (load_sel == 32'(k + 1)) key_d[k] = rx_buf_q;
                end
                if (!sel_ok) bad_d = 1'b1;
                state_d = StDone;
            end
            StCoreStart: begin
                core_start_d = 1'b1;
                state_d      = StCoreWait;
            end
            StCoreWait: begin
                if (core_done) begin
                    res_d   = core_result;
                    state_d = StTx;
                end
            end
            StTx: begin
                if (dma_error) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                end else if (dma_idle) begin
                    tx_start_d = 1'b1;
                    state_d    = StTxWait;
                end
            end
            StTxWait: begin
                if (dma_error) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                end else if (dma_done) begin
                    state_d = StDone;
                end else if (timeout_hit) begin
                    state_d = StErr;
                    tmo_d   = 1'b1;
                end
            end
            StDone, StErr: begin
                // Hold until the command is withdrawn so it is not re-executed.
                if (cmd == 32'd0 && load_sel == 32'd0) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q || !(state_q inside {StRxWait, StTxWait})) begin
            wait_cnt_d = 32'd0;
        end else begin
            wait_cnt_d = wait_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            job_cmp_q    <= 1'b0;
            wait_cnt_q   <= 32'd0;
            rx_buf_q     <= '0;
            msg_q        <= '0;
            res_q        <= '0;
            for (int k = 0; k < NUM_KEYS; k++) key_q[k] <= '0;
            err_q        <= 1'b0;
            tmo_q        <= 1'b0;
            bad_q        <= 1'b0;
            rx_start_q   <= 1'b0;
            tx_start_q   <= 1'b0;
            core_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            job_cmp_q    <= job_cmp_d;
            wait_cnt_q   <= wait_cnt_d;
            rx_buf_q     <= rx_buf_d;
            msg_q        <= msg_d;
            res_q        <= res_d;
            for (int k = 0; k < NUM_KEYS; k++) key_q[k] <= key_d[k];
            err_q        <= err_d;
            tmo_q        <= tmo_d;
            bad_q        <= bad_d;
            rx_start_q   <= rx_start_d;
            tx_start_q   <= tx_start_d;
            core_start_q <= core_start_d;
        end
    end

`ifdef CYCLE_COUNT_EN
    logic [31:0] cycles_q, cycles_d;

    always_comb begin
        cycles_d = cycles_q;
        if (state_q == StIdle && state_d == StRx && cmd == 32'd1) begin
            cycles_d = 32'd0;
        end else if (job_cmp_q && !(state_q inside {StIdle, StDone, StErr}) &&
                     cycles_q != 32'hFFFF_FFFF) begin
            cycles_d = cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cycles_q <= 32'd0;
        else         cycles_q <= cycles_d;
    end

    assign cycles = cycles_q;
`else
    assign cycles = 32'd0;
`endif

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key_bus
        assign key_bus[g*DW +: DW] = key_q[g];
    end

    assign status = {16'd0, load_sel[3:0], state_q, 3'd0, bad_q, tmo_q, err_q,
                     state_q == StIdle, state_q == StDone};

    assign dma_tx_data    = res_q;
    assign core_operand   = msg_q;
    assign dma_rx_address = rx_addr;
    assign dma_tx_address = tx_addr;
    assign dma_rx_start   = rx_start_q;
    assign dma_tx_start   = tx_start_q;
    assign core_start     = core_start_q;

endmodule
